// File: rtl/tod_bcd_counter.sv
// Time-of-day counter: six BCD digits (HH:MM:SS, 24-hour internal state) advanced by a
// one-second prescaler, with range-checked time-set load and 12/24-hour display mapping.
module tod_bcd_counter #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned INIT_HH       = 0,
  parameter int unsigned INIT_MM       = 0,
  parameter int unsigned INIT_SS       = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mode_12h,
  input  logic        set_valid,
  input  logic [23:0] set_bcd,
  output logic        set_ready,
  output logic        set_err,
  output logic [3:0]  bcd_h1,
  output logic [3:0]  bcd_h0,
  output logic [3:0]  bcd_m1,
  output logic [3:0]  bcd_m0,
  output logic [3:0]  bcd_s1,
  output logic [3:0]  bcd_s0,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_wrap
);

  localparam int unsigned   PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    INIT_H1    = 4'(INIT_HH / 10);
  localparam logic [3:0]    INIT_H0    = 4'(INIT_HH % 10);
  localparam logic [3:0]    INIT_M1    = 4'(INIT_MM / 10);
  localparam logic [3:0]    INIT_M0    = 4'(INIT_MM % 10);
  localparam logic [3:0]    INIT_S1    = 4'(INIT_SS / 10);
  localparam logic [3:0]    INIT_S0    = 4'(INIT_SS % 10);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic          set_ready_q, set_ready_d;
  logic          set_err_q, set_err_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          accept, load_ok, tick;
  logic [7:0]    disp_h;

  function automatic logic set_in_range(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    return (((h1 < 4'd2) && (h0 <= 4'd9)) || ((h1 == 4'd2) && (h0 <= 4'd3))) &&
           (m1 <= 4'd5) && (m0 <= 4'd9) && (s1 <= 4'd5) && (s0 <= 4'd9);
  endfunction

  // Internal hours are always a legal 00..23, so a 5-bit binary hour cannot overflow.
  function automatic logic [7:0] display_hour(input logic [3:0] h1, input logic [3:0] h0,
                                              input logic mode);
    logic [4:0] hb;
    hb = 5'(h1) * 5'd10 + 5'(h0);
    if (!mode) return {h1, h0};
    if (hb == 5'd0)       hb = 5'd12;
    else if (hb > 5'd12)  hb = hb - 5'd12;
    if (hb >= 5'd10) return {4'd1, 4'(hb - 5'd10)};
    return {4'd0, 4'(hb)};
  endfunction

  assign accept  = set_valid & set_ready_q;
  assign load_ok = set_in_range(set_bcd);
  assign tick    = en & (presc_q == PRESC_TERM);

  always_comb begin
    presc_d     = presc_q;
    {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
    set_ready_d = 1'b1;
    set_err_d   = accept & ~load_ok;
    sec_tick_d  = 1'b0;
    day_wrap_d  = 1'b0;
    if (accept && load_ok) begin
      // A valid load wins over a coincident tick and restarts the second.
      {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = set_bcd;
      presc_d = '0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        sec_tick_d = 1'b1;
        if (s0_q != 4'd9) s0_d = s0_q + 4'd1;
        else begin
          s0_d = 4'd0;
          if (s1_q != 4'd5) s1_d = s1_q + 4'd1;
          else begin
            s1_d = 4'd0;
            if (m0_q != 4'd9) m0_d = m0_q + 4'd1;
            else begin
              m0_d = 4'd0;
              if (m1_q != 4'd5) m1_d = m1_q + 4'd1;
              else begin
                m1_d = 4'd0;
                if ((h1_q == 4'd2) && (h0_q == 4'd3)) begin
                  h1_d       = 4'd0;
                  h0_d       = 4'd0;
                  day_wrap_d = 1'b1;
                end else if (h0_q == 4'd9) begin
                  h0_d = 4'd0;
                  h1_d = h1_q + 4'd1;
                end else begin
                  h0_d = h0_q + 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      h1_q        <= INIT_H1;
      h0_q        <= INIT_H0;
      m1_q        <= INIT_M1;
      m0_q        <= INIT_M0;
      s1_q        <= INIT_S1;
      s0_q        <= INIT_S0;
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      set_ready_q <= set_ready_d;
      set_err_q   <= set_err_d;
      sec_tick_q  <= sec_tick_d;
      day_wrap_q  <= day_wrap_d;
    end
  end

  assign disp_h    = display_hour(h1_q, h0_q, mode_12h);
  assign bcd_h1    = disp_h[7:4];
  assign bcd_h0    = disp_h[3:0];
  assign bcd_m1    = m1_q;
  assign bcd_m0    = m0_q;
  assign bcd_s1    = s1_q;
  assign bcd_s0    = s0_q;
  assign pm        = (h1_q == 4'd2) || ((h1_q == 4'd1) && (h0_q >= 4'd2));
  assign set_ready = set_ready_q;
  assign set_err   = set_err_q;
  assign sec_tick  = sec_tick_q;
  assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_tod_bcd_counter.sv
// Scoreboard bench for tod_bcd_counter: a seconds-of-day model predicts every cycle's outputs.
module tb_tod_bcd_counter;

  localparam int unsigned TPS  = 4;
  localparam int unsigned IHH  = 23;
  localparam int unsigned IMM  = 59;
  localparam int unsigned ISS  = 58;
  localparam int          INIT_SEC = IHH * 3600 + IMM * 60 + ISS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode_12h;
  logic        set_valid;
  logic [23:0] set_bcd;
  logic        set_ready, set_err, pm, sec_tick, day_wrap;
  logic [3:0]  bcd_h1, bcd_h0, bcd_m1, bcd_m0, bcd_s1, bcd_s0;

  tod_bcd_counter #(
    .TICKS_PER_SEC(TPS), .INIT_HH(IHH), .INIT_MM(IMM), .INIT_SS(ISS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_bcd(set_bcd), .set_ready(set_ready), .set_err(set_err),
    .bcd_h1(bcd_h1), .bcd_h0(bcd_h0), .bcd_m1(bcd_m1), .bcd_m0(bcd_m0),
    .bcd_s1(bcd_s1), .bcd_s0(bcd_s0), .pm(pm), .sec_tick(sec_tick), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] digits;
    logic        pm;
    logic        tick;
    logic        wrap;
    logic        err;
    logic        ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_sec;
  int   m_presc;
  logic m_ready;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [23:0] model_digits(input int sec, input logic mode);
    int hh, mm, ss;
    hh = sec / 3600;
    mm = (sec / 60) % 60;
    ss = sec % 60;
    if (mode) hh = (hh % 12 == 0) ? 12 : hh % 12;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int bcd_to_sec(input logic [23:0] b, output logic ok);
    int d[6];
    int hh, mm, ss;
    for (int i = 0; i < 6; i++) d[i] = int'(b[23 - 4*i -: 4]);
    hh = d[0] * 10 + d[1];
    mm = d[2] * 10 + d[3];
    ss = d[4] * 10 + d[5];
    ok = 1'b1;
    for (int i = 0; i < 6; i++) if (d[i] > 9) ok = 1'b0;
    if (hh > 23 || mm > 59 || ss > 59) ok = 1'b0;
    return hh * 3600 + mm * 60 + ss;
  endfunction

  task automatic model_reset();
    m_sec   = INIT_SEC;
    m_presc = 0;
    m_ready = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare them.
  task automatic step(input logic e, input logic md, input logic sv, input logic [23:0] sb);
    exp_t x;
    exp_t got;
    logic ok;
    int   nsec;
    @(negedge clk);
    en = e; mode_12h = md; set_valid = sv; set_bcd = sb;
    nsec = bcd_to_sec(sb, ok);
    x.tick = 1'b0; x.wrap = 1'b0;
    x.err  = sv && m_ready && !ok;
    if (sv && m_ready && ok) begin
      m_sec = nsec;
      m_presc = 0;
    end else if (e) begin
      if (m_presc == TPS - 1) begin
        m_presc = 0;
        x.tick = 1'b1;
        x.wrap = (m_sec == 86399);
        m_sec  = (m_sec + 1) % 86400;
      end else begin
        m_presc++;
      end
    end
    m_ready  = 1'b1;
    x.ready  = 1'b1;
    x.digits = model_digits(m_sec, md);
    x.pm     = (m_sec >= 12 * 3600);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_val("digits",   {8'd0, bcd_h1, bcd_h0, bcd_m1, bcd_m0, bcd_s1, bcd_s0}, {8'd0, got.digits});
    check_val("pm",       {31'd0, pm},        {31'd0, got.pm});
    check_val("sec_tick", {31'd0, sec_tick},  {31'd0, got.tick});
    check_val("day_wrap", {31'd0, day_wrap},  {31'd0, got.wrap});
    check_val("set_err",  {31'd0, set_err},   {31'd0, got.err});
    check_val("set_ready",{31'd0, set_ready}, {31'd0, got.ready});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_digits"}, {8'd0, bcd_h1, bcd_h0, bcd_m1, bcd_m0, bcd_s1, bcd_s0}, 32'h0023_5958);
    check_val({tag, "_ready"},  {31'd0, set_ready}, 32'd0);
    check_val({tag, "_pulses"}, {29'd0, sec_tick, day_wrap, set_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode_12h = 1'b0; set_valid = 1'b0; set_bcd = 24'h0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Roll over midnight from the INIT time.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 24'h0);

    // Carry chains.
    step(1'b1, 1'b0, 1'b1, 24'h095959);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b1, 24'h195959);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 24'h0);

    // Load coinciding with terminal count, then invalid requests.
    step(1'b1, 1'b0, 1'b1, 24'h000000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b1, 24'h123456);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b1, 24'h246000);
    step(1'b1, 1'b0, 1'b1, 24'h126A00);
    step(1'b1, 1'b0, 1'b0, 24'h0);

    // 12-hour display with time frozen.
    step(1'b0, 1'b1, 1'b1, 24'h001500);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b1, 24'h120000);
    step(1'b0, 1'b1, 1'b1, 24'h130507);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b1, 24'h235959);

    // Freeze mid-prescale, then resume.
    step(1'b1, 1'b0, 1'b1, 24'h105958);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 24'h0);

    // Asynchronous reset right after a carry edge, between clock edges.
    step(1'b1, 1'b0, 1'b1, 24'h095959);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 24'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 24'h010203);
    step(1'b1, 1'b0, 1'b1, 24'h010203);

    // Randomised tail.
    for (int i = 0; i < 60; i++) begin
      logic [23:0] sb;
      sb = ($urandom_range(0, 1) == 0) ?
           {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))} :
           24'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), sb);
    end

    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
